prog_mod_counter: RTL and testbench
===================================

// Module: prog_mod_counter
// PURPOSE
//  Generalised modulo counter: up/down, gated by enable, with a runtime-programmable
//  terminal value held in a shadow register and applied only at a wrap boundary.
//  Emits a one-cycle max_tick per wrap plus a wrap-event count.
//  Replaces fixed mod-M dividers: baud/pixel/refresh tick generation, with
//  reconfiguration at runtime without glitching an in-progress period.
// PARAMETERS
//  N      4   counter width in bits; modulus range 1..2^N
//  T_RST  9   terminal value (modulus-1) loaded into active and shadow regs at reset
//  W      8   width of the wrap-event counter wrap_cnt
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   asynchronous, active-high reset
//  en        in   1   count enable; counter holds when 0
//  clr       in   1   synchronous restart of the current period
//  up        in   1   1 = count up, 0 = count down; sampled every cycle
//  term_in   in   N   new terminal value (new modulus = term_in+1)
//  term_wr   in   1   strobe: capture term_in into the shadow register
//  q         out  N   current count (registered)
//  max_tick  out  1   terminal reached while enabled (combinational from regs, en, up)
//  pend      out  1   shadow term written but not yet applied (registered)
//  term_act  out  N   terminal value currently in force (registered)
//  wrap_cnt  out  W   number of wraps since reset/clr, wraps mod 2^W (registered)
// BEHAVIOUR
//  Reset (async): q=0, term_act=T_RST, shadow=T_RST, pend=0, wrap_cnt=0.
//  Terminal point: up -> q==term_act; down -> q==0.
//  max_tick = en & at_terminal & ~clr. One cycle per period; it is high every enabled cycle
//   when term_act==0 (mod-1).
//  Per-cycle priority, highest first:
//   1 clr: if pend, term_act<=shadow and pend<=0. q <= 0 (up) or the new term_act (down).
//     wrap_cnt <= 0. No tick.
//   2 en & at_terminal: wrap. q <= 0 (up) or the effective term_act (down). wrap_cnt++.
//     If pend, term_act<=shadow, pend<=0, and q reloads from the new value when counting down.
//   3 en: q <= q+1 (up) or q-1 (down).
//   4 otherwise: hold all state.
//  term_wr: shadow<=term_in and pend<=1. This holds in every case above, including
//   during a wrap or clr.
//   - A write in the same cycle as a wrap/clr is NOT applied in that cycle.
//     It stays pending until the next boundary.
//   - Repeated writes before a boundary: the last one wins.
//  Direction change mid-period: counting continues from the current q. There is no
//   reload and no tick. The next terminal check uses the new direction.
//  Out-of-range q is impossible by construction: a new terminal is applied only when
//   q is also reloaded.
//  Latency: q and the other registered outputs update one cycle after en/clr/term_wr.
//   max_tick has zero latency (same cycle as q==terminal).
//  All arithmetic is N-bit modulo 2^N. q never exceeds term_act. wrap_cnt rolls
//   over silently.
//  Reset mid-period: immediate return to the reset values. A pending shadow write is
//   discarded.
// STRUCTURE
//  Shared package (counter_pkg): direction constants DIR_UP=1'b1 and DIR_DN=1'b0.
//  Single module, no sub-modules. Three register groups:
//   - count q
//   - modulus: shadow, term_act, pend
//   - wrap_cnt
//  Next-state logic is one combinational block implementing the priority list.
// TESTING
//  T1 default, en=1, up=1: max_tick every 10th cycle at q=9, then q=0; wrap_cnt=3
//     after 30 enabled cycles.
//  T2 term_wr term_in=3 at q=5: pend=1, period stays 10 until the wrap at q=9. Then
//     term_act=3, pend=0, tick every 4 cycles.
//  T3 up=0 from reset: q 0->9->8..->0, tick at q=0. Flip up=1 at q=4: q=5, no tick.
//  T4 term_in=0 (mod-1), en=1: max_tick high every cycle, q stays 0, wrap_cnt
//     increments every cycle.
//  T5 clr with pend=1 at q=6 down: q=term_in, term_act=term_in, wrap_cnt=0, no tick.
//     A term_wr in the same cycle leaves pend=1.
//  T6 en toggled 1-0 pseudo-randomly and async reset asserted mid-period: q holds while
//     en=0. After reset, all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg
// Shared constants for the programmable modulo counter.
//   DIR_UP / DIR_DN : encodings of the 'up' direction input.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage : counter_pkg

// File: rtl/prog_mod_counter.sv
// prog_mod_counter
// Up/down modulo counter with a runtime-programmable terminal value.
// A new terminal value is written into a shadow register and takes effect only
// at the next period boundary (wrap or clr), so an in-progress period is never
// cut short or stretched by reconfiguration.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   en        in   count enable; counter holds when low
//   clr       in   synchronous restart of the current period
//   up        in   count direction (DIR_UP / DIR_DN)
//   term_in   in   new terminal value (modulus = term_in + 1)
//   term_wr   in   strobe capturing term_in into the shadow register
//   q         out  current count
//   max_tick  out  one-cycle pulse when the terminal point is reached while enabled
//   pend      out  shadow holds a value not yet applied
//   term_act  out  terminal value currently in force
//   wrap_cnt  out  wraps since reset/clr, modulo 2^W
module prog_mod_counter
    import counter_pkg::*;
#(
    parameter int N     = 4,
    parameter int T_RST = 9,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         up,
    input  logic [N-1:0] term_in,
    input  logic         term_wr,
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         pend,
    output logic [N-1:0] term_act,
    output logic [W-1:0] wrap_cnt
);

    localparam logic [N-1:0] TERM_RESET = N'(T_RST);

    logic [N-1:0] shadow;
    logic [N-1:0] q_nxt;
    logic [N-1:0] shadow_nxt;
    logic [N-1:0] term_act_nxt;
    logic         pend_nxt;
    logic [W-1:0] wrap_nxt;
    logic [N-1:0] term_eff;
    logic         at_terminal;

    // Terminal point depends on the direction sampled this cycle, so a
    // mid-period direction flip simply retargets the next check.
    assign at_terminal = (up == DIR_UP) ? (q == term_act) : (q == '0);
    assign max_tick    = en & at_terminal & ~clr;

    // Terminal that will be in force after a boundary: the shadow if one is
    // pending. The shadow register value (not term_in) is used, so a write in
    // the same cycle as a boundary waits for the following boundary.
    assign term_eff = pend ? shadow : term_act;

    // Next-state logic in priority order: clr, wrap, count, hold. The shadow
    // write is applied last so it always wins over the pend clear.
    always_comb begin
        q_nxt        = q;
        shadow_nxt   = shadow;
        term_act_nxt = term_act;
        pend_nxt     = pend;
        wrap_nxt     = wrap_cnt;

        if (clr) begin
            term_act_nxt = term_eff;
            pend_nxt     = 1'b0;
            q_nxt        = (up == DIR_UP) ? '0 : term_eff;
            wrap_nxt     = '0;
        end else if (en && at_terminal) begin
            term_act_nxt = term_eff;
            pend_nxt     = 1'b0;
            q_nxt        = (up == DIR_UP) ? '0 : term_eff;
            wrap_nxt     = wrap_cnt + W'(1);
        end else if (en) begin
            q_nxt = (up == DIR_UP) ? q + N'(1) : q - N'(1);
        end

        if (term_wr) begin
            shadow_nxt = term_in;
            pend_nxt   = 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

    // Modulus registers: shadow, active terminal and pending flag. Reset
    // discards any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow   <= TERM_RESET;
            term_act <= TERM_RESET;
            pend     <= 1'b0;
        end else begin
            shadow   <= shadow_nxt;
            term_act <= term_act_nxt;
            pend     <= pend_nxt;
        end
    end

    // Wrap-event counter; rolls over silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_cnt <= '0;
        end else begin
            wrap_cnt <= wrap_nxt;
        end
    end

endmodule : prog_mod_counter

// File: tb/tb_prog_mod_counter.sv
// tb_prog_mod_counter
// Directed, table-driven bench for prog_mod_counter (N=4, T_RST=9, W=8).
// Inputs change on the falling edge; max_tick is sampled just before the
// rising edge, registered outputs just after it.
module tb_prog_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       clr;
    logic       up;
    logic [3:0] term_in;
    logic       term_wr;
    logic [3:0] q;
    logic       max_tick;
    logic       pend;
    logic [3:0] term_act;
    logic [7:0] wrap_cnt;

    int compared;
    int mismatched;

    typedef struct {
        logic       en;
        logic       clr;
        logic       up;
        logic [3:0] term_in;
        logic       term_wr;
        logic       tick;
        logic [3:0] q;
        logic       pend;
        logic [3:0] term_act;
        logic [7:0] wrap;
    } vec_t;

    vec_t vecs[$];
    vec_t hand[$];

    prog_mod_counter #(.N(4), .T_RST(9), .W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clr      (clr),
        .up       (up),
        .term_in  (term_in),
        .term_wr  (term_wr),
        .q        (q),
        .max_tick (max_tick),
        .pend     (pend),
        .term_act (term_act),
        .wrap_cnt (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic c, input logic u,
                                input logic [3:0] ti, input logic tw,
                                input logic tk, input logic [3:0] eq,
                                input logic ep, input logic [3:0] et,
                                input logic [7:0] ew);
        vec_t v;
        v.en = e; v.clr = c; v.up = u; v.term_in = ti; v.term_wr = tw;
        v.tick = tk; v.q = eq; v.pend = ep; v.term_act = et; v.wrap = ew;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " q"}, int'(q), 0);
        checkOutput({tag, " term_act"}, int'(term_act), 9);
        checkOutput({tag, " pend"}, int'(pend), 0);
        checkOutput({tag, " wrap_cnt"}, int'(wrap_cnt), 0);
    endtask

    // Drive one vector on the falling edge, check the combinational tick
    // before the rising edge and the registered state after it.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        en = v.en; clr = v.clr; up = v.up; term_in = v.term_in; term_wr = v.term_wr;
        #1;
        checkOutput({tag, " max_tick"}, int'(max_tick), int'(v.tick));
        @(posedge clk);
        #1;
        checkOutput({tag, " q"}, int'(q), int'(v.q));
        checkOutput({tag, " pend"}, int'(pend), int'(v.pend));
        checkOutput({tag, " term_act"}, int'(term_act), int'(v.term_act));
        checkOutput({tag, " wrap_cnt"}, int'(wrap_cnt), int'(v.wrap));
    endtask

    task automatic pulseReset();
        @(negedge clk);
        en = 1'b0; clr = 1'b0; up = 1'b1; term_in = 4'd0; term_wr = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int   qm;
        logic ev;

        compared   = 0;
        mismatched = 0;
        en = 1'b0; clr = 1'b0; up = 1'b1; term_in = 4'd0; term_wr = 1'b0;
        reset = 1'b1;
        #12;
        checkReset("reset");
        checkOutput("reset max_tick", int'(max_tick), 0);
        @(negedge clk);
        reset = 1'b0;

        // T1: default mod-10 up counting for 30 enabled cycles.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            en = 1'b1; up = 1'b1;
            #1;
            checkOutput($sformatf("T1[%0d] max_tick", i), int'(max_tick), (i % 10 == 9) ? 1 : 0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("T1[%0d] q", i), int'(q), (i + 1) % 10);
        end
        checkOutput("T1 wrap_cnt", int'(wrap_cnt), 3);

        // Starting state: q=0, term_act=9, pend=0, wrap_cnt=3.
        // T2: reprogram to 3 at q=5; applies at the q=9 wrap.
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(1,0,1,0,0, 0, 4'(i), 0, 9, 3));
        vecs.push_back(mk(1,0,1,3,1, 0, 6, 1, 9, 3));
        vecs.push_back(mk(1,0,1,0,0, 0, 7, 1, 9, 3));
        vecs.push_back(mk(1,0,1,0,0, 0, 8, 1, 9, 3));
        vecs.push_back(mk(1,0,1,0,0, 0, 9, 1, 9, 3));
        vecs.push_back(mk(1,0,1,0,0, 1, 0, 0, 3, 4));
        vecs.push_back(mk(1,0,1,0,0, 0, 1, 0, 3, 4));
        vecs.push_back(mk(1,0,1,0,0, 0, 2, 0, 3, 4));
        vecs.push_back(mk(1,0,1,0,0, 0, 3, 0, 3, 4));
        vecs.push_back(mk(1,0,1,0,0, 1, 0, 0, 3, 5));
        // T4: mod-1, tick every enabled cycle in both directions.
        vecs.push_back(mk(1,0,1,0,1, 0, 1, 1, 3, 5));
        vecs.push_back(mk(1,0,1,0,0, 0, 2, 1, 3, 5));
        vecs.push_back(mk(1,0,1,0,0, 0, 3, 1, 3, 5));
        vecs.push_back(mk(1,0,1,0,0, 1, 0, 0, 0, 6));
        vecs.push_back(mk(1,0,1,0,0, 1, 0, 0, 0, 7));
        vecs.push_back(mk(1,0,1,0,0, 1, 0, 0, 0, 8));
        vecs.push_back(mk(1,0,0,0,0, 1, 0, 0, 0, 9));
        // Write during a wrap stays pending until the next boundary.
        vecs.push_back(mk(1,0,1,9,1, 1, 0, 1, 0, 10));
        vecs.push_back(mk(1,0,1,0,0, 1, 0, 0, 9, 11));
        for (int i = 1; i <= 6; i++) vecs.push_back(mk(1,0,1,0,0, 0, 4'(i), 0, 9, 11));
        // T5: clr with pend at q=6 counting down, plus same-cycle write.
        vecs.push_back(mk(0,0,1,5,1, 0, 6, 1, 9, 11));
        vecs.push_back(mk(1,1,0,7,1, 0, 5, 1, 5, 0));
        vecs.push_back(mk(1,0,0,0,0, 0, 4, 1, 5, 0));
        vecs.push_back(mk(0,1,1,0,0, 0, 0, 0, 7, 0));
        vecs.push_back(mk(0,0,0,0,0, 0, 0, 0, 7, 0));
        // Repeated writes: last one wins.
        vecs.push_back(mk(0,0,1,2,1, 0, 0, 1, 7, 0));
        vecs.push_back(mk(0,0,1,4,1, 0, 0, 1, 7, 0));
        vecs.push_back(mk(0,1,1,0,0, 0, 0, 0, 4, 0));
        // Down wrap with pending value reloads q from the new terminal.
        vecs.push_back(mk(1,0,0,6,1, 1, 4, 1, 4, 1));
        vecs.push_back(mk(1,0,0,0,0, 0, 3, 1, 4, 1));
        vecs.push_back(mk(1,0,0,0,0, 0, 2, 1, 4, 1));
        vecs.push_back(mk(1,0,0,0,0, 0, 1, 1, 4, 1));
        vecs.push_back(mk(1,0,0,0,0, 0, 0, 1, 4, 1));
        vecs.push_back(mk(1,0,0,0,0, 1, 6, 0, 6, 2));

        foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec[%0d]", i));

        // T3: count down from reset, then flip direction at q=4.
        pulseReset();
        #1;
        checkReset("T3 reset");
        hand.push_back(mk(1,0,0,0,0, 1, 9, 0, 9, 1));
        for (int i = 8; i >= 4; i--) hand.push_back(mk(1,0,0,0,0, 0, 4'(i), 0, 9, 1));
        hand.push_back(mk(1,0,1,0,0, 0, 5, 0, 9, 1));
        hand.push_back(mk(1,0,1,0,0, 0, 6, 0, 9, 1));
        // Switch to mod-1 for the wrap counter rollover run.
        hand.push_back(mk(0,0,1,0,1, 0, 6, 1, 9, 1));
        hand.push_back(mk(0,1,1,0,0, 0, 0, 0, 0, 0));
        foreach (hand[i]) applyStimulus(hand[i], $sformatf("hand[%0d]", i));

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            en = 1'b1; clr = 1'b0; up = 1'b1; term_wr = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("rollover wrap_cnt", int'(wrap_cnt), 0);
        @(posedge clk);
        #1;
        checkOutput("rollover wrap_cnt+1", int'(wrap_cnt), 1);

        // T6: pseudo-random enable against a mod-10 reference, then an
        // asynchronous reset mid-period with a pending write.
        pulseReset();
        qm = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ev = 1'($urandom_range(0, 1));
            en = ev; clr = 1'b0; up = 1'b1; term_wr = 1'b0;
            #1;
            checkOutput($sformatf("T6[%0d] max_tick", i), int'(max_tick), (ev && qm == 9) ? 1 : 0);
            @(posedge clk);
            #1;
            if (ev) qm = (qm == 9) ? 0 : qm + 1;
            checkOutput($sformatf("T6[%0d] q", i), int'(q), qm);
        end
        @(negedge clk);
        en = 1'b1; term_in = 4'd2; term_wr = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("T6 pend before reset", int'(pend), 1);
        @(negedge clk);
        en = 1'b1; term_wr = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkReset("T6 async reset");
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("T6 q after release", int'(q), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_prog_mod_counter
